acq_sequencer: RTL and testbench
================================

Name: acq_sequencer

Overview:
- Acquisition controller for the oscilloscope sample path.
- Sequences the decimation counter by driving its write-enable and its decimation value, and consumes the decimated sample strobe.
- Generates the circular sample-memory write address, qualifies the trigger, runs pre-trigger and post-trigger sample counts, and reports completion to the host-interface logic.

Parameters:
- ADDR_W, 10, sample memory address width; buffer depth is 2^ADDR_W.
- DEC_W, 24, decimation value width.
- TIMEOUT_W, 24, auto-trigger timeout counter width (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins an acquisition.
- ABORT  in  1  one-cycle pulse; stops any acquisition.
- DEC_CFG  in  DEC_W  decimation value from the config register.
- PRETRIG_CFG  in  ADDR_W  number of samples to capture before the trigger is armed.
- TRIG  in  1  trigger condition, level, synchronous to CLK.
- SMP_EN  in  1  decimated sample strobe from the decimation counter.
- Start_WR  out  1  run enable to the decimation counter.
- DEC_OUT  out  DEC_W  latched decimation value to the decimation counter.
- WR_EN  out  1  sample memory write strobe.
- WR_ADDR  out  ADDR_W  address for the current WR_EN.
- TRIG_ADDR  out  ADDR_W  address of the trigger sample.
- BUSY  out  1  high while an acquisition is in progress.
- READY  out  1  acquisition complete; buffer is valid.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the internal pointer wr_ptr is 0.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- A sample is "taken" on a cycle where SMP_EN=1, Start_WR=1, state is PRE, WAIT_TRIG or POST, and ABORT=0. SMP_EN is ignored in every other case.
- Each taken sample:
  - next cycle: WR_EN=1 for one cycle, with WR_ADDR=wr_ptr;
  - wr_ptr increments modulo 2^ADDR_W.
  - Write latency is 1 cycle from SMP_EN.
- IDLE or DONE, when START=1 and ABORT=0:
  - DEC_OUT<=DEC_CFG;
  - pre_cnt<=PRETRIG_CFG;
  - wr_ptr<=0;
  - READY<=0, BUSY<=1, Start_WR<=1;
  - go to PRE, or to WAIT_TRIG if PRETRIG_CFG=0.
  - DEC_OUT and PRETRIG_CFG are held constant for the whole acquisition.
- START while BUSY=1 is ignored.
- PRE:
  - each taken sample decrements pre_cnt;
  - on the taken sample where pre_cnt=1, go to WAIT_TRIG;
  - TRIG is ignored in PRE.
- WAIT_TRIG:
  - a taken sample with TRIG=1 is the trigger sample;
  - TRIG_ADDR<=wr_ptr;
  - post_cnt<=2^ADDR_W-1-PRETRIG_CFG;
  - go to POST, or straight to DONE if that value is 0.
  - Writes keep wrapping the buffer while waiting.
  - TRIG with no taken sample on that cycle has no effect.
- POST:
  - each taken sample decrements post_cnt;
  - on the taken sample where post_cnt=1, go to DONE.
  - Total samples written from the trigger sample onward is 2^ADDR_W-PRETRIG_CFG.
- DONE entry: Start_WR<=0, BUSY<=0, READY<=1. READY holds until START, ABORT or RST.
- The final WR_EN still occurs on the cycle after the last taken sample.
- ABORT, in any state, goes to IDLE next cycle:
  - Start_WR=0, BUSY=0, READY=0;
  - no WR_EN is generated for a same-cycle SMP_EN;
  - TRIG_ADDR is retained.
- Priority: RST > ABORT > START.
- RST mid-acquisition takes effect next edge, with outputs as at reset.
- Width rules:
  - all counters are ADDR_W bits;
  - post_cnt subtraction is modulo 2^ADDR_W;
  - PRETRIG_CFG=2^ADDR_W-1 gives post_cnt=0, so the trigger sample is the last write.

Optional Feature:
- Macro: AUTO_TRIG_EN.
- Defined:
  - adds input AUTO_TMO (TIMEOUT_W bits) and output AUTO_FLAG (1 bit);
  - in WAIT_TRIG, a clock counter starts at 0 on entry and increments every CLK;
  - when the counter equals AUTO_TMO and AUTO_TMO is nonzero, the next taken sample is treated as the trigger sample regardless of TRIG, and AUTO_FLAG<=1;
  - a real TRIG before the timeout leaves AUTO_FLAG=0;
  - AUTO_FLAG clears on START, ABORT and RST;
  - AUTO_TMO=0 disables the timeout.
- Undefined: the ports are absent and WAIT_TRIG waits indefinitely for TRIG.

Test Plan:
- ADDR_W=4, PRETRIG_CFG=4, DEC_CFG=3, SMP_EN every 4 clocks, TRIG held 1 -> addresses 0-3 written, trigger at the 5th sample, TRIG_ADDR=4, 12 writes total from the trigger, READY=1, Start_WR=0, last WR_ADDR=15.
- TRIG held 0 for 40 samples, then pulsed with a sample -> WR_ADDR wraps 15->0, TRIG_ADDR=(40 mod 16)=8, then 11 more writes, READY=1.
- ABORT in POST on the same cycle as SMP_EN -> no WR_EN, Start_WR=0 next cycle, BUSY=0, READY=0; following START restarts at WR_ADDR=0.
- PRETRIG_CFG=0 and PRETRIG_CFG=15 -> the first sample can trigger (16 post writes); with 15, DONE immediately after the trigger sample write.
- START while BUSY, and TRIG during PRE -> both ignored, and state/counters are unchanged.
- AUTO_TRIG_EN, AUTO_TMO=20, TRIG=0 -> trigger forced at the first sample after 20 clocks in WAIT_TRIG, AUTO_FLAG=1; AUTO_TMO=0 -> never triggers.

Source files
------------

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: drives the decimation counter, writes the circular sample buffer,
// and runs pre/post-trigger counts. Optional auto-trigger timeout under `AUTO_TRIG_EN.
module acq_sequencer #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEC_W     = 24,
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [DEC_W-1:0]     DEC_CFG,
    input  logic [ADDR_W-1:0]    PRETRIG_CFG,
    input  logic                 TRIG,
    input  logic                 SMP_EN,
`ifdef AUTO_TRIG_EN
    input  logic [TIMEOUT_W-1:0] AUTO_TMO,
    output logic                 AUTO_FLAG,
`endif
    output logic                 Start_WR,
    output logic [DEC_W-1:0]     DEC_OUT,
    output logic                 WR_EN,
    output logic [ADDR_W-1:0]    WR_ADDR,
    output logic [ADDR_W-1:0]    TRIG_ADDR,
    output logic                 BUSY,
    output logic                 READY
);

    typedef enum logic [2:0] {StIdle, StPre, StWaitTrig, StPost, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] pre_cnt_q;
    logic [ADDR_W-1:0] post_cnt_q;
    logic [ADDR_W-1:0] pre_cfg_q;
    logic [ADDR_W-1:0] post_init;
    logic              taken;
    logic              trig_fire;

    always_comb begin
        taken = SMP_EN && Start_WR && !ABORT
                && (state_q == StPre || state_q == StWaitTrig || state_q == StPost);
        // Depth-1-pretrig modulo 2^ADDR_W is the bitwise complement.
        post_init = ~pre_cfg_q;
    end

`ifdef AUTO_TRIG_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic                 tmo_expired;

    always_comb begin
        tmo_expired = (AUTO_TMO != '0) && (tmo_cnt_q >= AUTO_TMO);
        trig_fire   = TRIG || tmo_expired;
    end

    // Clock counter runs only in WAIT_TRIG and saturates so it cannot wrap back below the timeout.
    always_ff @(posedge CLK) begin
        if (RST || state_q != StWaitTrig) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_w;

    assign unused_timeout_w = (TIMEOUT_W == 0);
    assign trig_fire        = TRIG;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            pre_cfg_q  <= '0;
            Start_WR   <= 1'b0;
            DEC_OUT    <= '0;
            WR_EN      <= 1'b0;
            WR_ADDR    <= '0;
            TRIG_ADDR  <= '0;
            BUSY       <= 1'b0;
            READY      <= 1'b0;
`ifdef AUTO_TRIG_EN
            AUTO_FLAG  <= 1'b0;
`endif
        end else begin
            WR_EN <= taken;
            if (taken) begin
                WR_ADDR  <= wr_ptr_q;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            if (ABORT) begin
                state_q  <= StIdle;
                Start_WR <= 1'b0;
                BUSY     <= 1'b0;
                READY    <= 1'b0;
`ifdef AUTO_TRIG_EN
                AUTO_FLAG <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (START) begin
                            DEC_OUT   <= DEC_CFG;
                            pre_cnt_q <= PRETRIG_CFG;
                            pre_cfg_q <= PRETRIG_CFG;
                            wr_ptr_q  <= '0;
                            READY     <= 1'b0;
                            BUSY      <= 1'b1;
                            Start_WR  <= 1'b1;
`ifdef AUTO_TRIG_EN
                            AUTO_FLAG <= 1'b0;
`endif
                            state_q   <= (PRETRIG_CFG == '0) ? StWaitTrig : StPre;
                        end
                    end
                    StPre: begin
                        if (taken) begin
                            pre_cnt_q <= pre_cnt_q - 1'b1;
                            if (pre_cnt_q == ADDR_W'(1)) begin
                                state_q <= StWaitTrig;
                            end
                        end
                    end
                    StWaitTrig: begin
                        if (taken && trig_fire) begin
                            TRIG_ADDR  <= wr_ptr_q;
                            post_cnt_q <= post_init;
`ifdef AUTO_TRIG_EN
                            AUTO_FLAG  <= !TRIG;
`endif
                            if (post_init == '0) begin
                                state_q  <= StDone;
                                Start_WR <= 1'b0;
                                BUSY     <= 1'b0;
                                READY    <= 1'b1;
                            end else begin
                                state_q <= StPost;
                            end
                        end
                    end
                    StPost: begin
                        if (taken) begin
                            post_cnt_q <= post_cnt_q - 1'b1;
                            if (post_cnt_q == ADDR_W'(1)) begin
                                state_q  <= StDone;
                                Start_WR <= 1'b0;
                                BUSY     <= 1'b0;
                                READY    <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer (default build). Expected write sequences come from
// sample indices: sample k lands at k mod depth, trigger ends the run depth-pretrig samples later.
module tb_acq_sequencer;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned TW    = 8;
    localparam int          DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          ABORT;
    logic [DW-1:0] DEC_CFG;
    logic [AW-1:0] PRETRIG_CFG;
    logic          TRIG;
    logic          SMP_EN;
    logic          Start_WR;
    logic [DW-1:0] DEC_OUT;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [AW-1:0] TRIG_ADDR;
    logic          BUSY;
    logic          READY;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_log[$];

    acq_sequencer #(
        .ADDR_W   (AW),
        .DEC_W    (DW),
        .TIMEOUT_W(TW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .ABORT      (ABORT),
        .DEC_CFG    (DEC_CFG),
        .PRETRIG_CFG(PRETRIG_CFG),
        .TRIG       (TRIG),
        .SMP_EN     (SMP_EN),
        .Start_WR   (Start_WR),
        .DEC_OUT    (DEC_OUT),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .TRIG_ADDR  (TRIG_ADDR),
        .BUSY       (BUSY),
        .READY      (READY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WR_EN === 1'b1) wr_log.push_back(WR_ADDR);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // One full acquisition: trigger at sample trig_idx (>= pre), gaps of gmin..gmax idle clocks.
    task automatic run_acq(input int pre, input int trig_idx, input int gmin, input int gmax);
        int            total;
        logic [DW-1:0] dec;
        total = trig_idx + DEPTH - pre;
        dec   = DW'($urandom);
        wr_log.delete();
        @(negedge CLK);
        START = 1'b1; DEC_CFG = dec; PRETRIG_CFG = AW'(pre); SMP_EN = 1'b0; TRIG = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || Start_WR !== 1'b1 || READY !== 1'b0) begin
            errors++;
            $display("FAIL start_flags: busy=%b start_wr=%b ready=%b, required 1 1 0",
                     BUSY, Start_WR, READY);
        end
        for (int k = 0; k < total; k++) begin
            repeat ($urandom_range(gmin, gmax)) begin
                SMP_EN = 1'b0;
                TRIG   = 1'($urandom_range(0, 1));
                START  = ($urandom_range(0, 5) == 0);
                @(negedge CLK);
            end
            SMP_EN = 1'b1;
            TRIG   = (k < pre || k > trig_idx) ? 1'($urandom_range(0, 1)) : (k == trig_idx);
            START  = ($urandom_range(0, 5) == 0);
            @(negedge CLK);
        end
        SMP_EN = 1'b0; TRIG = 1'b0; START = 1'b0;
        repeat (2) @(negedge CLK);

        checks++;
        if (wr_log.size() != total) begin
            errors++;
            $display("FAIL write_count: got %0d, required %0d (pre=%0d trig=%0d)",
                     wr_log.size(), total, pre, trig_idx);
        end
        for (int k = 0; k < total && k < wr_log.size(); k++) begin
            checks++;
            if (wr_log[k] !== AW'(k % DEPTH)) begin
                errors++;
                $display("FAIL wr_addr[%0d]: got %0d, required %0d", k, wr_log[k], k % DEPTH);
            end
        end
        checks++;
        if (TRIG_ADDR !== AW'(trig_idx % DEPTH)) begin
            errors++;
            $display("FAIL trig_addr: got %0d, required %0d", TRIG_ADDR, trig_idx % DEPTH);
        end
        checks++;
        if (READY !== 1'b1 || BUSY !== 1'b0 || Start_WR !== 1'b0) begin
            errors++;
            $display("FAIL done_flags: ready=%b busy=%b start_wr=%b, required 1 0 0",
                     READY, BUSY, Start_WR);
        end
        checks++;
        if (DEC_OUT !== dec) begin
            errors++;
            $display("FAIL dec_out: got %0h, required %0h", DEC_OUT, dec);
        end

        // Strobes after completion must not write and READY must hold.
        repeat (3) begin
            SMP_EN = 1'b1; TRIG = 1'b1;
            @(negedge CLK);
        end
        SMP_EN = 1'b0; TRIG = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (wr_log.size() != total || READY !== 1'b1) begin
            errors++;
            $display("FAIL after_done: writes=%0d ready=%b, required %0d 1",
                     wr_log.size(), READY, total);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({WR_EN, Start_WR, BUSY, READY} !== 4'b0 || WR_ADDR !== '0 || TRIG_ADDR !== '0
            || DEC_OUT !== '0) begin
            errors++;
            $display("FAIL reset: wr_en=%b start_wr=%b busy=%b ready=%b addr=%0d taddr=%0d dec=%0h, required all 0",
                     WR_EN, Start_WR, BUSY, READY, WR_ADDR, TRIG_ADDR, DEC_OUT);
        end
        RST = 1'b0;
    endtask

    task automatic test_basic();
        run_acq(4, 4, 3, 3);
        checks++;
        if (WR_ADDR !== AW'(DEPTH - 1)) begin
            errors++;
            $display("FAIL basic_last_addr: got %0d, required %0d", WR_ADDR, DEPTH - 1);
        end
    endtask

    task automatic test_wrap();
        run_acq(4, 40, 0, 2);
    endtask

    task automatic test_pretrig_edges();
        run_acq(0, 0, 0, 1);
        run_acq(DEPTH - 1, DEPTH - 1, 0, 1);
    endtask

    task automatic test_abort();
        wr_log.delete();
        @(negedge CLK);
        START = 1'b1; PRETRIG_CFG = AW'(4); DEC_CFG = 8'h5a;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 0; k < 7; k++) begin
            SMP_EN = 1'b1; TRIG = (k == 4);
            @(negedge CLK);
            SMP_EN = 1'b0; TRIG = 1'b0;
            @(negedge CLK);
        end
        SMP_EN = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        SMP_EN = 1'b0; ABORT = 1'b0;
        checks++;
        if (WR_EN !== 1'b0 || Start_WR !== 1'b0 || BUSY !== 1'b0 || READY !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: wr_en=%b start_wr=%b busy=%b ready=%b, required 0 0 0 0",
                     WR_EN, Start_WR, BUSY, READY);
        end
        checks++;
        if (TRIG_ADDR !== AW'(4) || wr_log.size() != 7) begin
            errors++;
            $display("FAIL abort_state: trig_addr=%0d writes=%0d, required 4 7",
                     TRIG_ADDR, wr_log.size());
        end
        SMP_EN = 1'b1;
        @(negedge CLK);
        SMP_EN = 1'b0;
        @(negedge CLK);
        checks++;
        if (wr_log.size() != 7) begin
            errors++;
            $display("FAIL abort_idle_sample: writes=%0d, required 7", wr_log.size());
        end
        run_acq(2, 3, 0, 1);
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        START = 1'b1; PRETRIG_CFG = AW'(6); DEC_CFG = 8'h11;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) begin
            SMP_EN = 1'b1;
            @(negedge CLK);
        end
        SMP_EN = 1'b1; RST = 1'b1;
        @(negedge CLK);
        SMP_EN = 1'b0; RST = 1'b0;
        checks++;
        if ({WR_EN, Start_WR, BUSY, READY} !== 4'b0 || WR_ADDR !== '0 || DEC_OUT !== '0) begin
            errors++;
            $display("FAIL reset_mid: wr_en=%b start_wr=%b busy=%b ready=%b addr=%0d dec=%0h, required all 0",
                     WR_EN, Start_WR, BUSY, READY, WR_ADDR, DEC_OUT);
        end
        run_acq(1, 5, 0, 2);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int pre;
            pre = $urandom_range(0, DEPTH - 1);
            run_acq(pre, pre + $urandom_range(0, 20), 0, 3);
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; TRIG = 1'b0; SMP_EN = 1'b0;
        DEC_CFG = '0; PRETRIG_CFG = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_pretrig_edges();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
